// File: rtl/fp32pe_ctrl.sv
// Job sequencer for one 8-lane fp32 dot-product PE: clears the accumulators, streams
// operand-buffer reads, waits out the PE pipeline and returns the captured result.
module fp32pe_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned CLR_CYC   = 2,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned DRAIN_LAT = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [LEN_W-1:0]  job_len,
  input  logic [ADDR_W-1:0] job_base_a,
  input  logic [ADDR_W-1:0] job_base_b,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              pe_clr,
  input  logic [31:0]       pe_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              busy
);

  localparam int unsigned DRN_CYC = RD_LAT + DRAIN_LAT;
  localparam int unsigned DRN_W   = $clog2(DRN_CYC + 1);
  localparam int unsigned CLR_W   = $clog2(CLR_CYC + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DRN_W-1:0]  drn_cnt_q, drn_cnt_d;
  logic [ADDR_W-1:0] addr_a_d, addr_b_d;
  logic [31:0]       res_data_d;

  // State, counters and registered outputs; output flags decode the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      beat_cnt_q <= '0;
      drn_cnt_q  <= '0;
      rd_addr_a  <= '0;
      rd_addr_b  <= '0;
      res_data   <= '0;
      job_ready  <= 1'b1;
      pe_clr     <= 1'b1;
      rd_en      <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      drn_cnt_q  <= drn_cnt_d;
      rd_addr_a  <= addr_a_d;
      rd_addr_b  <= addr_b_d;
      res_data   <= res_data_d;
      job_ready  <= (state_d == IDLE);
      pe_clr     <= (state_d == IDLE) || (state_d == CLEAR);
      rd_en      <= (state_d == ISSUE);
      res_valid  <= (state_d == DONE);
      busy       <= (state_d != IDLE);
    end
  end

  // Next-state logic; abort outranks every transition outside IDLE
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    beat_cnt_d = beat_cnt_q;
    drn_cnt_d  = drn_cnt_q;
    addr_a_d   = rd_addr_a;
    addr_b_d   = rd_addr_b;
    res_data_d = res_data;
    if ((state_q != IDLE) && abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (job_valid) begin
            addr_a_d   = job_base_a;
            addr_b_d   = job_base_b;
            beat_cnt_d = job_len;
            clr_cnt_d  = CLR_W'(CLR_CYC - 1);
            if (job_len == '0) begin
              state_d    = DONE;
              res_data_d = '0;
            end else begin
              state_d = CLEAR;
            end
          end
        end
        CLEAR: begin
          if (clr_cnt_q == '0) state_d = ISSUE;
          else                 clr_cnt_d = clr_cnt_q - CLR_W'(1);
        end
        ISSUE: begin
          // Address registers advance after each beat so the outputs never glitch
          addr_a_d   = rd_addr_a + ADDR_W'(1);
          addr_b_d   = rd_addr_b + ADDR_W'(1);
          beat_cnt_d = beat_cnt_q - LEN_W'(1);
          if (beat_cnt_q == LEN_W'(1)) begin
            state_d   = DRAIN;
            drn_cnt_d = DRN_W'(DRN_CYC - 1);
          end
        end
        DRAIN: begin
          if (drn_cnt_q == '0) begin
            state_d    = DONE;
            res_data_d = pe_out;
          end else begin
            drn_cnt_d = drn_cnt_q - DRN_W'(1);
          end
        end
        DONE: begin
          if (res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32pe_ctrl.sv
// Randomized scoreboard bench for fp32pe_ctrl against a cycle-timing reference model.
module tb_fp32pe_ctrl;

  localparam int CLR = 2;
  localparam int RDL = 1;
  localparam int DRL = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [9:0]  job_len = '0;
  logic [9:0]  job_base_a = '0;
  logic [9:0]  job_base_b = '0;
  logic        abort = 1'b0;
  logic        rd_en;
  logic [9:0]  rd_addr_a;
  logic [9:0]  rd_addr_b;
  logic        pe_clr;
  logic [31:0] pe_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit rand_bp = 1'b0;
  bit fixed_ready = 1'b1;

  typedef struct { int c; logic [9:0] a; logic [9:0] b; } beat_t;
  typedef struct { int c; logic [31:0] d; } res_t;
  beat_t beat_q[$];
  res_t  res_q[$];

  bit m_busy = 1'b0;
  int t_acc = 0;
  int t_res = 0;
  int m_len = 0;
  int last_acc = 0;
  int last_hs = 0;

  fp32pe_ctrl dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_len(job_len), .job_base_a(job_base_a), .job_base_b(job_base_b),
    .abort(abort), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .pe_clr(pe_clr), .pe_out(pe_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PE stand-in: a distinct, cycle-dependent value so the capture instant is observable
  function automatic logic [31:0] pe_fn(input int c);
    return (32'(c) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  assign pe_out = pe_fn(cyc);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      res_ready = rand_bp ? ($urandom_range(0, 2) != 0) : fixed_ready;
    end
  end

  // Reference model and monitor: check this cycle, then advance the model
  initial begin
    bit e_rd, e_clr, e_rv;
    beat_t b;
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_job_ready", 32'(job_ready), 1);
        chk("rst_pe_clr", 32'(pe_clr), 1);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rd_addr_a", 32'(rd_addr_a), 0);
        chk("rst_rd_addr_b", 32'(rd_addr_b), 0);
        chk("rst_res_data", res_data, 0);
        m_busy = 1'b0;
        beat_q.delete();
        res_q.delete();
      end else begin
        e_rd  = m_busy && (m_len != 0) && (cyc > t_acc + CLR) && (cyc <= t_acc + CLR + m_len);
        e_clr = !m_busy || ((m_len != 0) && (cyc <= t_acc + CLR));
        e_rv  = m_busy && (cyc >= t_res);
        chk("job_ready", 32'(job_ready), 32'(!m_busy));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rd_en", 32'(rd_en), 32'(e_rd));
        chk("pe_clr", 32'(pe_clr), 32'(e_clr));
        chk("res_valid", 32'(res_valid), 32'(e_rv));
        if (rd_en) begin
          if (beat_q.size() == 0) chk("rd_en_unexpected", 32'(rd_en), 0);
          else begin
            b = beat_q.pop_front();
            chk("beat_cycle", 32'(cyc), 32'(b.c));
            chk("rd_addr_a", 32'(rd_addr_a), 32'(b.a));
            chk("rd_addr_b", 32'(rd_addr_b), 32'(b.b));
          end
        end
        if (res_valid) begin
          if (res_q.size() == 0) chk("res_valid_unexpected", 32'(res_valid), 0);
          else chk("res_data", res_data, res_q[0].d);
        end
        if (!m_busy) begin
          if (job_valid) begin
            m_busy = 1'b1;
            t_acc = cyc;
            last_acc = cyc;
            m_len = int'(job_len);
            t_res = (m_len == 0) ? cyc + 1 : cyc + CLR + m_len + RDL + DRL + 1;
            for (int i = 0; i < m_len; i++) begin
              b.c = cyc + CLR + 1 + i;
              b.a = job_base_a + 10'(i);
              b.b = job_base_b + 10'(i);
              beat_q.push_back(b);
            end
            r.c = t_res;
            r.d = (m_len == 0) ? 32'h0 : pe_fn(t_res - 1);
            res_q.push_back(r);
          end
        end else if (abort) begin
          m_busy = 1'b0;
          beat_q.delete();
          res_q.delete();
        end else if ((cyc >= t_res) && res_ready) begin
          m_busy = 1'b0;
          last_hs = cyc;
          void'(res_q.pop_front());
        end
      end
    end
  end

  task automatic drive_job(input int len, input int a, input int b);
    @(posedge clk); #1;
    job_valid = 1'b1;
    job_len = 10'(len);
    job_base_a = 10'(a);
    job_base_b = 10'(b);
  endtask

  task automatic await_accept();
    int n = 0;
    @(negedge clk);
    while (!job_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) chk("accept_timeout", 32'(job_ready), 1);
    @(posedge clk); #1;
    job_valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || !job_ready) && n < 3000);
    if (busy) chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  initial begin
    int n;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    drive_job(4, 'h010, 'h200); await_accept(); wait_idle();
    drive_job(4, 'h3FE, 'h3FD); await_accept(); wait_idle();
    drive_job(0, 'h123, 'h321); await_accept(); wait_idle();

    // Backpressure with a second job queued behind the held result
    fixed_ready = 1'b0;
    drive_job(3, 'h040, 'h080); await_accept();
    n = 0;
    while (!res_valid && n < 200) begin @(negedge clk); n++; end
    chk("bp_res_valid_seen", 32'(res_valid), 1);
    repeat (20) @(negedge clk);
    drive_job(5, 'h100, 'h1F0);
    fixed_ready = 1'b1;
    await_accept();
    chk("b2b_accept_gap", 32'(last_acc - last_hs), 1);
    wait_idle();

    // Abort in the second ISSUE cycle
    drive_job(8, 'h020, 'h300); await_accept();
    n = 0;
    while (!rd_en && n < 50) begin @(negedge clk); n++; end
    chk("abort_first_beat_seen", 32'(rd_en), 1);
    pulse_abort();
    @(negedge clk);
    chk("abort_rd_en", 32'(rd_en), 0);
    chk("abort_pe_clr", 32'(pe_clr), 1);
    chk("abort_job_ready", 32'(job_ready), 1);
    wait_cycles(60);
    drive_job(2, 'h055, 'h0AA); await_accept(); wait_idle();

    // Abort coinciding with the handshake is ignored; abort in IDLE is ignored
    drive_job(3, 'h011, 'h022); abort = 1'b1; await_accept(); wait_idle();
    pulse_abort(); wait_cycles(2);

    // Reset in the middle of a job
    drive_job(10, 'h0F0, 'h0E0); await_accept();
    wait_cycles(6);
    rst = 1'b0;
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(50);

    rand_bp = 1'b1;
    for (int j = 0; j < 30; j++) begin
      int l;
      l = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
      drive_job(l, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 7) == 0) abort = 1'b1;
      await_accept();
      if ($urandom_range(0, 4) == 0) begin
        wait_cycles(int'($urandom_range(0, 60)));
        pulse_abort();
      end
      wait_idle();
      if ($urandom_range(0, 5) == 0) pulse_abort();
      wait_cycles(int'($urandom_range(0, 3)));
    end
    rand_bp = 1'b0;
    wait_idle();
    wait_cycles(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
